// File: rtl/task_dispatcher_pkg.sv
// -----------------------------------------------------------------------------
// task_pkg
// Shared types and sizing for the task dispatcher of the virtualized BMW-PIFO.
//   task_t   : packed FIFO word {op, tree_id, data}
//   state_e  : dispatcher FSM states
//   OP_PUSH / OP_POP : values of task_t.op
// -----------------------------------------------------------------------------
package task_pkg;

  localparam int PTW           = 16;                  // payload width
  localparam int TREE_NUM      = 4;                   // number of virtual trees
  localparam int TREE_NUM_BITS = $clog2(TREE_NUM);    // tree id width
  localparam int TASK_W        = PTW + TREE_NUM_BITS + 1;
  localparam int TREE_CAP_DEF  = 64;                  // default elements per tree
  localparam int TAG_DEPTH_DEF = 8;                   // default outstanding pops

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  typedef struct packed {
    logic                     op;
    logic [TREE_NUM_BITS-1:0] tree_id;
    logic [PTW-1:0]           data;
  } task_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    ISSUE     = 2'd2
  } state_e;

  function automatic task_t make_task(input logic op,
                                      input logic [TREE_NUM_BITS-1:0] tree_id,
                                      input logic [PTW-1:0] data);
    task_t t;
    t.op      = op;
    t.tree_id = tree_id;
    t.data    = data;
    return t;
  endfunction

endpackage

// File: rtl/task_dispatcher_if.sv
// -----------------------------------------------------------------------------
// task_dispatcher_if
// Operation/result bus between the dispatcher and the shared SRAM PIFO core.
//   master (dispatcher): drives push/pop strobes, tree id and push payload;
//                        receives ready and in-order pop results.
//   slave  (core)      : the mirror view.
// -----------------------------------------------------------------------------
interface task_dispatcher_if;
  import task_pkg::*;

  logic                     pifo_ready;
  logic                     pifo_push;
  logic                     pifo_pop;
  logic [TREE_NUM_BITS-1:0] pifo_tree_id;
  logic [PTW-1:0]           pifo_push_data;
  logic                     pifo_pop_valid;
  logic [PTW-1:0]           pifo_pop_data;

  modport master (
    input  pifo_ready, pifo_pop_valid, pifo_pop_data,
    output pifo_push, pifo_pop, pifo_tree_id, pifo_push_data
  );

  modport slave (
    output pifo_ready, pifo_pop_valid, pifo_pop_data,
    input  pifo_push, pifo_pop, pifo_tree_id, pifo_push_data
  );

endinterface

// File: rtl/task_dispatcher_tag_queue.sv
// -----------------------------------------------------------------------------
// tag_queue
// Synchronous FIFO of tree ids for pops awaiting a core result.
//   clk, rst   : clock, synchronous active-low reset
//   enq/enq_data : push an id (ignored when full)
//   deq        : pop the head (ignored when empty); deq_data shows the head
//   full/empty : occupancy flags
// Enqueue and dequeue in the same cycle both take effect.
// -----------------------------------------------------------------------------
module tag_queue
  import task_pkg::*;
#(
  parameter int W     = TREE_NUM_BITS,
  parameter int DEPTH = TAG_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enq,
  input  logic [W-1:0] enq_data,
  input  logic         deq,
  output logic [W-1:0] deq_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_enq;
  logic          do_deq;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_enq   = enq && !full;
  assign do_deq   = deq && !empty;
  assign deq_data = mem[rd_ptr];

  // NOTE: storage needs no reset -- an entry is only read after being written,
  // and leaving it out of reset keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (do_enq) mem[wr_ptr] <= enq_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + AW'(1);
      if (do_deq) rd_ptr <= rd_ptr + AW'(1);
      case ({do_enq, do_deq})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/task_dispatcher.sv
// -----------------------------------------------------------------------------
// task_dispatcher
// Reader side of the per-tree task FIFO: fetches packed tasks, issues push/pop
// to the shared PIFO core (gated by per-tree occupancy) and returns pop results
// tagged with their tree id.
//   clk, rst        : clock, synchronous active-low reset
//   fifo_*          : task FIFO read port (data valid the cycle after rd_en)
//   pifo            : core operation/result bus (master view)
//   o_pop_*         : tagged pop result, one-cycle valid
//   o_drop_cnt      : saturating count of dropped tasks
//   o_err_orphan    : sticky, a result arrived with no outstanding pop
//   o_busy          : FSM not idle or pops still outstanding
// -----------------------------------------------------------------------------
module task_dispatcher
  import task_pkg::*;
#(
  parameter int TREE_CAP  = TREE_CAP_DEF,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  input  logic [TASK_W-1:0]        fifo_task,
  task_dispatcher_if.master        pifo,
  output logic                     o_pop_valid,
  output logic [TREE_NUM_BITS-1:0] o_pop_tree_id,
  output logic [PTW-1:0]           o_pop_data,
  output logic [15:0]              o_drop_cnt,
  output logic                     o_err_orphan,
  output logic                     o_busy
);

  localparam int CNT_W = $clog2(TREE_CAP + 1);

  state_e                   state, state_nx;
  task_t                    task_q;
  logic [CNT_W-1:0]         occ [TREE_NUM];
  logic [CNT_W-1:0]         cur_occ;
  logic                     is_push;
  logic                     issue_push, issue_pop, drop;
  logic                     tq_full, tq_empty, tq_deq;
  logic [TREE_NUM_BITS-1:0] tq_head;

  assign is_push = (task_q.op == OP_PUSH);
  assign cur_occ = occ[task_q.tree_id];
  assign tq_deq  = pifo.pifo_pop_valid && !tq_empty;

  tag_queue #(.W(TREE_NUM_BITS), .DEPTH(TAG_DEPTH)) u_tag_queue (
    .clk      (clk),
    .rst      (rst),
    .enq      (issue_pop),
    .enq_data (task_q.tree_id),
    .deq      (tq_deq),
    .deq_data (tq_head),
    .full     (tq_full),
    .empty    (tq_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_nx   = state;
    fifo_rd_en = 1'b0;
    issue_push = 1'b0;
    issue_pop  = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_nx   = WAIT_DATA;
        end
      end
      WAIT_DATA: state_nx = ISSUE;
      ISSUE: begin
        if (is_push && cur_occ == CNT_W'(TREE_CAP))      drop = 1'b1;
        else if (!is_push && cur_occ == '0)              drop = 1'b1;
        else if (!is_push && tq_full)                    drop = 1'b0; // stall
        else if (pifo.pifo_ready) begin
          issue_push = is_push;
          issue_pop  = !is_push;
        end
        // Chain straight into the next read so back-to-back tasks take 2 cycles.
        if (drop || issue_push || issue_pop) begin
          if (!fifo_empty) begin
            fifo_rd_en = 1'b1;
            state_nx   = WAIT_DATA;
          end else begin
            state_nx   = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Id/payload come from the task latch, so they hold steady while the core
  // keeps ready low; only the strobes depend on ready.
  assign pifo.pifo_push      = issue_push;
  assign pifo.pifo_pop       = issue_pop;
  assign pifo.pifo_tree_id   = (state == ISSUE) ? task_q.tree_id : '0;
  assign pifo.pifo_push_data = (state == ISSUE && is_push) ? task_q.data : '0;

  assign o_busy = (state != IDLE) || !tq_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      task_q        <= '0;
      o_drop_cnt    <= '0;
      o_err_orphan  <= 1'b0;
      o_pop_valid   <= 1'b0;
      o_pop_tree_id <= '0;
      o_pop_data    <= '0;
      for (int i = 0; i < TREE_NUM; i++) occ[i] <= '0;
    end else begin
      if (state == WAIT_DATA) task_q <= task_t'(fifo_task);

      if (issue_push) occ[task_q.tree_id] <= cur_occ + CNT_W'(1);
      if (issue_pop)  occ[task_q.tree_id] <= cur_occ - CNT_W'(1);

      if (drop && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;

      if (pifo.pifo_pop_valid && tq_empty) o_err_orphan <= 1'b1;

      o_pop_valid   <= tq_deq;
      o_pop_tree_id <= tq_deq ? tq_head : '0;
      o_pop_data    <= tq_deq ? pifo.pifo_pop_data : '0;
    end
  end

endmodule

// File: doc/task_dispatcher.md
Name: task_dispatcher

Overview:
Reader side of the per-tree task FIFO in the virtualized BMW-PIFO.
- Pops packed tasks {op(1=push,0=pop), tree_id, push_data} from the FIFO and decodes them.
- Issues push/pop operations to the shared SRAM PIFO core, gated by per-tree occupancy tracking.
- Returns pop results to the requester tagged with the originating tree id, using an in-order tag queue.

Parameters:
PTW, 16, payload width
TREE_NUM, 4, number of virtual trees
TREE_NUM_BITS, $clog2(TREE_NUM), tree id width
TASK_W, PTW+TREE_NUM_BITS+1, packed task width
TREE_CAP, 64, max elements per virtual tree
CNT_W, $clog2(TREE_CAP+1), per-tree occupancy counter width
TAG_DEPTH, 8, max outstanding pops awaiting results (power of 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
fifo_empty  in  1  task FIFO empty flag
fifo_rd_en  out  1  task FIFO read strobe
fifo_task  in  TASK_W  FIFO read data; valid the cycle after fifo_rd_en, zero otherwise
pifo_ready  in  1  core accepts an operation this cycle
pifo_push  out  1  push strobe (one cycle)
pifo_pop  out  1  pop strobe (one cycle)
pifo_tree_id  out  TREE_NUM_BITS  target tree
pifo_push_data  out  PTW  push payload
pifo_pop_valid  in  1  core pop result valid; results arrive in issue order
pifo_pop_data  in  PTW  core pop result
o_pop_valid  out  1  tagged result valid
o_pop_tree_id  out  TREE_NUM_BITS  tree of returned result
o_pop_data  out  PTW  returned result
o_drop_cnt  out  16  dropped tasks, saturating at 16'hFFFF
o_err_orphan  out  1  sticky flag: result received with no outstanding pop
o_busy  out  1  FSM not IDLE or tag queue non-empty

Behaviour:
- Reset (rst==0 at posedge):
  - FSM to IDLE; all outputs 0.
  - Occupancy counters, tag queue, drop count and orphan flag cleared.
  - A task whose read was already requested is discarded.
- FSM states and transitions:
  - IDLE: if !fifo_empty, assert fifo_rd_en for one cycle and go to WAIT_DATA.
  - WAIT_DATA: register fifo_task into the task latch; go to ISSUE.
  - ISSUE: decode the latched task and apply exactly one of:
    - push with occ[id]==TREE_CAP: drop, o_drop_cnt++, no core op.
    - pop with occ[id]==0: drop, o_drop_cnt++, no core op.
    - pop with tag queue full: stall in ISSUE.
    - otherwise: wait for pifo_ready; in the ready cycle, drive the strobe, tree id and data (push_data 0 on pops). A push does occ[id]++; a pop does occ[id]-- and enqueues id to the tag queue.
  - On leaving ISSUE (issue or drop): if !fifo_empty, assert fifo_rd_en in the same cycle and go to WAIT_DATA; else go to IDLE.
  - Maximum throughput is one task per 2 cycles.
  - Core outputs are registered-stable while waiting; strobes are high only in the accept cycle.
- Result path:
  - pifo_pop_valid with tag queue non-empty: next cycle o_pop_valid=1, o_pop_tree_id=dequeued tag, o_pop_data=pifo_pop_data.
  - pifo_pop_valid with tag queue empty: ignored; o_err_orphan set until reset.
- Simultaneous tag enqueue and dequeue: queue count unchanged, both take effect. Queue pointers wrap modulo TAG_DEPTH.
- Occupancy counters only ever change by ±1 per cycle and never wrap (guarded by the drop rules).

Decomposition:
- Package task_pkg:
  - task_t packed struct {op, tree_id, data}.
  - OP_PUSH=1, OP_POP=0.
  - FSM state enum {IDLE, WAIT_DATA, ISSUE}.
- Sub-module tag_queue: synchronous FIFO of TREE_NUM_BITS-wide ids, depth TAG_DEPTH, with same-cycle enqueue/dequeue support and full/empty outputs.

Test Plan:
- Push tree 2 data 0x00AA, then pop tree 2; core returns 0x00AA three cycles after the pop strobe -> pifo_push then pifo_pop issued; o_pop_valid with tree_id=2, data=0x00AA; o_drop_cnt=0.
- Pop tree 1 at occupancy 0 -> no pifo_pop strobe; o_drop_cnt=1; FSM returns to IDLE.
- TREE_CAP+1 pushes to tree 0 -> exactly 64 push strobes; o_drop_cnt=1.
- Hold pifo_ready=0 for 5 cycles with a pending push -> pifo_tree_id/pifo_push_data stable, pifo_push=0 throughout; one strobe on the first ready cycle.
- 9 pops with no core results (tag queue full at 8) -> 9th stalls in ISSUE; one pifo_pop_valid releases it; returned tags come out in issue order.
- Assert rst=0 in WAIT_DATA, and separately pulse pifo_pop_valid with the queue empty -> all outputs 0 after reset; o_err_orphan=1 and stays set.
